// File: rtl/arm_pipelined_mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage.
// Data has priority, fetch is protected from starvation, and a watchdog abandons stuck transactions.
module arm_pipelined_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              i_CLK,
  input  logic              i_RESET,
  input  logic              i_Fetch_Req,
  input  logic [ADDR_W-1:0] i_Fetch_Addr,
  output logic [DATA_W-1:0] o_Fetch_Instr,
  output logic              o_Fetch_Valid,
  input  logic              i_Data_Req,
  input  logic              i_Data_We,
  input  logic [ADDR_W-1:0] i_Data_Addr,
  input  logic [DATA_W-1:0] i_Data_WData,
  output logic [DATA_W-1:0] o_Data_RData,
  output logic              o_Data_Valid,
  input  logic              i_Flush,
  output logic              o_Stall_Fetch,
  output logic              o_Stall_Mem,
  output logic              o_Mem_Req,
  output logic              o_Mem_We,
  output logic [ADDR_W-1:0] o_Mem_Addr,
  output logic [DATA_W-1:0] o_Mem_WData,
  input  logic              i_Mem_Ready,
  input  logic [DATA_W-1:0] i_Mem_RData,
  output logic              o_Error,
  output logic [1:0]        o_Dbg_State
);

  // Handshakes: a requester holds Req (and its address/data) until its Valid
  // pulses; the memory transaction completes on the edge where
  // o_Mem_Req & i_Mem_Ready, and o_Mem_Req is never withdrawn before that
  // edge except on watchdog timeout or reset.

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;

  logic fetch_elig;
  logic data_elig;
  logic grant_data;
  logic grant_fetch;
  logic wait_expired;

  // A requester whose Valid is high this cycle is completing and must not be re-granted.
  always_comb begin
    fetch_elig   = i_Fetch_Req & ~o_Fetch_Valid & ~i_Flush;
    data_elig    = i_Data_Req & ~o_Data_Valid;
    grant_data   = data_elig & ((starve_cnt < STARVE_MAX) | ~fetch_elig);
    grant_fetch  = fetch_elig & ~grant_data;
    wait_expired = ~i_Mem_Ready & (wait_cnt == WAIT_LAST);
  end

  assign o_Stall_Fetch = i_Fetch_Req & ~o_Fetch_Valid;
  assign o_Stall_Mem   = i_Data_Req & ~o_Data_Valid;
  assign o_Dbg_State   = state;

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state         <= S_IDLE;
      starve_cnt    <= '0;
      wait_cnt      <= '0;
      o_Mem_Req     <= 1'b0;
      o_Mem_We      <= 1'b0;
      o_Mem_Addr    <= '0;
      o_Mem_WData   <= '0;
      o_Fetch_Instr <= '0;
      o_Fetch_Valid <= 1'b0;
      o_Data_RData  <= '0;
      o_Data_Valid  <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      o_Fetch_Valid <= 1'b0;
      o_Data_Valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_data) begin
            state       <= S_DATA;
            wait_cnt    <= '0;
            o_Mem_Req   <= 1'b1;
            o_Mem_We    <= i_Data_We;
            o_Mem_Addr  <= i_Data_Addr;
            o_Mem_WData <= i_Data_WData;
            if (fetch_elig && starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end else if (grant_fetch) begin
            state      <= S_FETCH;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            o_Mem_Req  <= 1'b1;
            o_Mem_We   <= 1'b0;
            o_Mem_Addr <= i_Fetch_Addr;
          end
        end

        S_FETCH: begin
          if (i_Mem_Ready) begin
            state     <= S_IDLE;
            o_Mem_Req <= 1'b0;
            o_Mem_We  <= 1'b0;
            // A flush landing on the completion edge discards the word.
            if (!i_Flush) begin
              o_Fetch_Instr <= i_Mem_RData;
              o_Fetch_Valid <= 1'b1;
            end
          end else if (wait_expired) begin
            state     <= S_IDLE;
            o_Mem_Req <= 1'b0;
            o_Mem_We  <= 1'b0;
            o_Error   <= 1'b1;
          end else if (i_Flush) begin
            state    <= S_DRAIN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        S_DATA: begin
          if (i_Mem_Ready) begin
            state        <= S_IDLE;
            o_Mem_Req    <= 1'b0;
            o_Mem_We     <= 1'b0;
            o_Data_Valid <= 1'b1;
            if (!o_Mem_We) begin
              o_Data_RData <= i_Mem_RData;
            end
          end else if (wait_expired) begin
            state     <= S_IDLE;
            o_Mem_Req <= 1'b0;
            o_Mem_We  <= 1'b0;
            o_Error   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        S_DRAIN: begin
          // The flushed fetch still owns the port until memory answers.
          if (i_Mem_Ready) begin
            state     <= S_IDLE;
            o_Mem_Req <= 1'b0;
            o_Mem_We  <= 1'b0;
          end else if (wait_expired) begin
            state     <= S_IDLE;
            o_Mem_Req <= 1'b0;
            o_Mem_We  <= 1'b0;
            o_Error   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          o_Mem_Req <= 1'b0;
          o_Mem_We  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arm_pipelined_mem_arbiter.sv
// Directed bench for arm_pipelined_mem_arbiter: fetch, contention, flush, store,
// watchdog timeout with reset, and starvation ordering.
module tb_arm_pipelined_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_instr;
  logic          fetch_valid;
  logic          data_req;
  logic          data_we;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_valid;
  logic          flush;
  logic          stall_fetch;
  logic          stall_mem;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          error;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] exp_q[$];

  arm_pipelined_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4), .TIMEOUT(8)
  ) dut (
    .i_CLK(clk), .i_RESET(rst),
    .i_Fetch_Req(fetch_req), .i_Fetch_Addr(fetch_addr),
    .o_Fetch_Instr(fetch_instr), .o_Fetch_Valid(fetch_valid),
    .i_Data_Req(data_req), .i_Data_We(data_we), .i_Data_Addr(data_addr),
    .i_Data_WData(data_wdata), .o_Data_RData(data_rdata), .o_Data_Valid(data_valid),
    .i_Flush(flush), .o_Stall_Fetch(stall_fetch), .o_Stall_Mem(stall_mem),
    .o_Mem_Req(mem_req), .o_Mem_We(mem_we), .o_Mem_Addr(mem_addr),
    .o_Mem_WData(mem_wdata), .i_Mem_Ready(mem_ready), .i_Mem_RData(mem_rdata),
    .o_Error(error), .o_Dbg_State(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", error); end
    total++; if (fetch_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", fetch_instr); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_fetch;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    #1;
    total++; if (stall_fetch !== 1'b1) begin bad++; $display("FAIL sf_stall_c0 got=%b want=1", stall_fetch); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL sf_req_c0 got=%b want=0", mem_req); end
    step();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL sf_req_c1 got=%b want=1", mem_req); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL sf_addr_c1 got=%h want=100", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL sf_we_c1 got=%b want=0", mem_we); end
    total++; if (stall_fetch !== 1'b1) begin bad++; $display("FAIL sf_stall_c1 got=%b want=1", stall_fetch); end
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL sf_state_c1 got=%0d want=1", dbg_state); end
    mem_ready = 1'b1; mem_rdata = 32'hE3A01005;
    step();
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL sf_valid_c2 got=%b want=1", fetch_valid); end
    total++; if (fetch_instr !== 32'hE3A01005) begin bad++; $display("FAIL sf_instr_c2 got=%h want=e3a01005", fetch_instr); end
    total++; if (stall_fetch !== 1'b0) begin bad++; $display("FAIL sf_stall_c2 got=%b want=0", stall_fetch); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL sf_state_c2 got=%0d want=0", dbg_state); end
    fetch_req = 1'b0; mem_ready = 1'b0;
    step();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL sf_valid_c3 got=%b want=0", fetch_valid); end
  endtask

  task automatic test_contention;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200;
    step();
    total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL ct_addr_c1 got=%h want=200", mem_addr); end
    total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL ct_state_c1 got=%0d want=2", dbg_state); end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    step();
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL ct_dvalid_c2 got=%b want=1", data_valid); end
    total++; if (data_rdata !== 32'h12345678) begin bad++; $display("FAIL ct_rdata_c2 got=%h want=12345678", data_rdata); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ct_req_c2 got=%b want=0", mem_req); end
    data_req = 1'b0; mem_rdata = 32'hE1A00000;
    #1;
    total++; if (stall_mem !== 1'b0 || stall_fetch !== 1'b1) begin bad++; $display("FAIL ct_stalls_c2 got=%b%b want=01", stall_mem, stall_fetch); end
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin bad++; $display("FAIL ct_freq_c3 got=%b/%h want=1/100", mem_req, mem_addr); end
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hE1A00000) begin bad++; $display("FAIL ct_fvalid_c4 got=%b/%h want=1/e1a00000", fetch_valid, fetch_instr); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ct_dvalid_c4 got=%b want=0", data_valid); end
    fetch_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_flush;
    fetch_req = 1'b1; fetch_addr = 32'h300;
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL fl_req_c1 got=%b/%h want=1/300", mem_req, mem_addr); end
    flush = 1'b1;
    step();
    flush = 1'b0; fetch_addr = 32'h400;
    total++; if (dbg_state !== 2'd3) begin bad++; $display("FAIL fl_state_c2 got=%0d want=3", dbg_state); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL fl_hold_c2 got=%b/%h want=1/300", mem_req, mem_addr); end
    step();
    total++; if (mem_req !== 1'b1 || fetch_valid !== 1'b0) begin bad++; $display("FAIL fl_hold_c3 got=%b/%b want=1/0", mem_req, fetch_valid); end
    step();
    total++; if (mem_req !== 1'b1 || dbg_state !== 2'd3) begin bad++; $display("FAIL fl_hold_c4 got=%b/%0d want=1/3", mem_req, dbg_state); end
    mem_ready = 1'b1; mem_rdata = 32'hBADBAD00;
    step();
    mem_ready = 1'b0;
    total++; if (mem_req !== 1'b0 || fetch_valid !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL fl_drained_c5 got=%b/%b/%0d want=0/0/0", mem_req, fetch_valid, dbg_state); end
    total++; if (fetch_instr !== 32'hE1A00000) begin bad++; $display("FAIL fl_instr_c5 got=%h want=e1a00000", fetch_instr); end
    step();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin bad++; $display("FAIL fl_refetch_c6 got=%b/%h want=1/400", mem_req, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'hE3A02007;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hE3A02007) begin bad++; $display("FAIL fl_fvalid_c7 got=%b/%h want=1/e3a02007", fetch_valid, fetch_instr); end
    mem_ready = 1'b0; fetch_addr = 32'h504;
    step();
    // flush coinciding with the ready edge
    step();
    total++; if (dbg_state !== 2'd1 || mem_addr !== 32'h504) begin bad++; $display("FAIL flr_grant got=%0d/%h want=1/504", dbg_state, mem_addr); end
    flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h55555555;
    step();
    flush = 1'b0; mem_ready = 1'b0;
    total++; if (fetch_valid !== 1'b0 || fetch_instr !== 32'hE3A02007) begin bad++; $display("FAIL flr_discard got=%b/%h want=0/e3a02007", fetch_valid, fetch_instr); end
    step();
    total++; if (mem_req !== 1'b1 || dbg_state !== 2'd1) begin bad++; $display("FAIL flr_regrant got=%b/%0d want=1/1", mem_req, dbg_state); end
    mem_ready = 1'b1; mem_rdata = 32'hE2800001;
    step();
    total++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'hE2800001) begin bad++; $display("FAIL flr_fvalid got=%b/%h want=1/e2800001", fetch_valid, fetch_instr); end
    fetch_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_store_wait;
    data_req = 1'b1; data_we = 1'b1; data_addr = 32'h40; data_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 3; c++) begin
      step();
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
        bad++; $display("FAIL st_hold_c%0d got=%b/%b/%h/%h want=1/1/40/deadbeef", c, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (c == 2) begin data_addr = 32'hFFF; data_wdata = 32'h0; end
      if (c == 3) mem_ready = 1'b1;
    end
    step();
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL st_dvalid got=%b want=1", data_valid); end
    total++; if (data_rdata !== 32'h12345678) begin bad++; $display("FAIL st_rdata got=%h want=12345678", data_rdata); end
    data_req = 1'b0; data_we = 1'b0; mem_ready = 1'b0;
    step();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL st_dvalid_off got=%b want=0", data_valid); end
  endtask

  task automatic test_timeout_reset;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h80;
    for (int c = 1; c <= 8; c++) begin
      step();
      total++;
      if (mem_req !== 1'b1 || data_valid !== 1'b0 || error !== 1'b0) begin
        bad++; $display("FAIL to_wait_c%0d got=%b/%b/%b want=1/0/0", c, mem_req, data_valid, error);
      end
    end
    step();
    total++; if (mem_req !== 1'b0 || error !== 1'b1 || data_valid !== 1'b0 || dbg_state !== 2'd0) begin bad++; $display("FAIL to_abandon got=%b/%b/%b/%0d want=0/1/0/0", mem_req, error, data_valid, dbg_state); end
    data_req = 1'b0;
    step();
    step();
    total++; if (error !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b/%b want=1/0", error, mem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (error !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        fetch_instr !== 32'h0 || data_rdata !== 32'h0 || fetch_valid !== 1'b0 || data_valid !== 1'b0) begin
      bad++; $display("FAIL to_reset_clear got=err%b req%b addr%h wd%h ins%h rd%h want=all zero", error, mem_req, mem_addr, mem_wdata, fetch_instr, data_rdata);
    end
    step();
  endtask

  task automatic test_starvation;
    logic prev_req;
    logic [AW-1:0] exp_addr;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int d = 0; d < 4; d++) exp_q.push_back(32'h200);
      exp_q.push_back(32'h100);
    end
    fetch_req = 1'b1; fetch_addr = 32'h100;
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h200;
    mem_ready = 1'b0;
    prev_req = 1'b0;
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      step();
      if (mem_req && !prev_req) begin
        exp_addr = exp_q.pop_front();
        total++;
        if (mem_addr !== exp_addr) begin bad++; $display("FAIL sv_grant cyc=%0d got=%h want=%h", cyc, mem_addr, exp_addr); end
      end
      prev_req = mem_req;
    end
    if (exp_q.size() != 0) begin
      total++; bad++; $display("FAIL sv_budget got=%0d grants missing want=0", exp_q.size());
    end
    fetch_req = 1'b0; data_req = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_single_fetch();
    test_contention();
    test_flush();
    test_store_wait();
    test_timeout_reset();
    test_starvation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_pipelined_mem_arbiter.md
# arm_pipelined_mem_arbiter

Shares a single unified memory port between the pipeline's instruction-fetch stage and its data-memory stage. Load/store traffic, as steered by the decoder's memory-write and memory-to-register controls, takes priority over fetch, and a bounded-starvation counter guarantees fetch progress. The block drives stall requests to the hazard unit. It sits between the Fetch/Memory stages and the external memory interface, and also handles branch-flush discard and a memory-timeout watchdog.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 4: after this many consecutive data grants while fetch waits, the next grant goes to fetch.
- `TIMEOUT`, default 255: maximum wait cycles per memory transaction before it is abandoned.
- `i_CLK` input, 1 bit: clock, rising edge.
- `i_RESET` input, 1 bit: synchronous, active-high reset.
- `i_Fetch_Req` input, 1 bit: fetch request; held until `o_Fetch_Valid`.
- `i_Fetch_Addr` input, ADDR_W bits: fetch address (PC).
- `o_Fetch_Instr` output, DATA_W bits: fetched word, valid with `o_Fetch_Valid`.
- `o_Fetch_Valid` output, 1 bit: one-cycle completion pulse.
- `i_Data_Req` input, 1 bit: load/store request; held until `o_Data_Valid`.
- `i_Data_We` input, 1 bit: 1 = store, 0 = load.
- `i_Data_Addr` input, ADDR_W bits: data address.
- `i_Data_WData` input, DATA_W bits: store data.
- `o_Data_RData` output, DATA_W bits: load data, valid with `o_Data_Valid`.
- `o_Data_Valid` output, 1 bit: one-cycle completion pulse.
- `i_Flush` input, 1 bit: branch taken; discard any fetch in flight.
- `o_Stall_Fetch` output, 1 bit: `i_Fetch_Req & ~o_Fetch_Valid`.
- `o_Stall_Mem` output, 1 bit: `i_Data_Req & ~o_Data_Valid`.
- `o_Mem_Req` output, 1 bit: memory transaction active.
- `o_Mem_We` output, 1 bit: write strobe.
- `o_Mem_Addr` output, ADDR_W bits: memory address.
- `o_Mem_WData` output, DATA_W bits: memory write data.
- `i_Mem_Ready` input, 1 bit: transaction completes at the clock edge where `o_Mem_Req & i_Mem_Ready`.
- `i_Mem_RData` input, DATA_W bits: read data, sampled at completion.
- `o_Error` output, 1 bit: sticky timeout flag.

## Operation
- **States:**
  - IDLE: arbitrates.
  - FETCH: fetch transaction in progress.
  - DATA: data transaction in progress.
  - DRAIN: flushed fetch in progress; result is discarded.
- **IDLE arbitration.** A request is eligible if asserted and not completing this cycle (its Valid is low). `i_Flush` makes fetch ineligible that cycle.
  - Data eligible, and starvation count < STARVE_LIMIT or fetch not eligible → DATA.
  - Otherwise, fetch eligible → FETCH.
  - On grant, latch address, write data and the We bit into output registers. `o_Mem_We` is 0 for fetch.
- **Starvation counter** (width clog2(STARVE_LIMIT+1)):
  - Increments on each data grant made while fetch is eligible.
  - Clears on each fetch grant.
  - Saturates at STARVE_LIMIT.
- **FETCH/DATA.** `o_Mem_Req`=1 and address/data are held stable.
  - On ready: capture `i_Mem_RData` into `o_Fetch_Instr` or `o_Data_RData`, pulse the matching Valid next cycle, go to IDLE.
  - Stores also pulse `o_Data_Valid`; `o_Data_RData` is unchanged.
- **Flush.**
  - `i_Flush` in FETCH without ready → DRAIN.
  - `i_Flush` in FETCH with ready the same cycle → IDLE, no Valid pulse.
  - `i_Flush` in DATA or DRAIN: ignored.
- **DRAIN.** `o_Mem_Req` is held (transactions are never withdrawn). On ready → IDLE with no Valid pulse.
- **Watchdog.**
  - Wait counter clears on entry to any non-IDLE state and increments each cycle without ready.
  - When the counter reaches TIMEOUT without ready: set `o_Error`, drop `o_Mem_Req`, go to IDLE, no Valid pulse. The requester re-arbitrates.
  - `o_Error` stays set until reset.
- **Reset.**
  - State IDLE; all counters 0.
  - `o_Mem_Req`, `o_Mem_We`, both Valids and `o_Error` are 0.
  - `o_Mem_Addr`, `o_Mem_WData`, `o_Fetch_Instr` and `o_Data_RData` are 0.
  - Reset mid-transaction abandons the transaction immediately; no Valid pulse.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: `o_Mem_Req`=1. If ready in cycle 1, the Valid is high in cycle 2 and the state is IDLE in cycle 2.
- Minimum latency is request to Valid = 2 cycles. Each extra wait cycle adds 1.
- Back-to-back: the completing requester is ignored in its Valid cycle. A pending other requester is granted in that same IDLE cycle, so the next `o_Mem_Req` is in cycle 3.
- Stall outputs are combinational from the inputs and the registered Valids. All other outputs are registered.
- `o_Mem_Req` never deasserts before ready, except on timeout or reset.

## Test plan
- **Single fetch.** Fetch req, addr 0x100, ready in the first cycle, RData 0xE3A01005 → `o_Mem_Req` in cycle 1, `o_Fetch_Valid` in cycle 2 with instr 0xE3A01005, `o_Stall_Fetch` high in cycles 0-1.
- **Contention.** Fetch and data (load 0x200) asserted together → data served first. Fetch `o_Mem_Req` in cycle 3, `o_Fetch_Valid` in cycle 4.
- **Starvation.** Fetch held while data is re-requested continuously, STARVE_LIMIT=4 → exactly 4 data grants, then a fetch grant, then the counter restarts.
- **Flush.** Fetch granted, ready held low 3 cycles, `i_Flush` pulsed in wait cycle 1 → DRAIN, `o_Mem_Req` held until ready, no `o_Fetch_Valid`, next fetch arbitrates afterwards.
- **Store with wait.** Store addr 0x40, data 0xDEADBEEF, ready after 2 wait cycles → `o_Mem_We`=1 and addr/data stable over all 3 req cycles, `o_Data_Valid` one cycle later.
- **Timeout and reset.** Ready never asserted, TIMEOUT=8 → `o_Mem_Req` drops after 8 wait cycles, `o_Error`=1 and sticky, no Valid. A following `i_RESET` pulse clears `o_Error` and all outputs.
